// File: rtl/axi_lite_data_ram.sv
// AXI4-Lite slave data memory for the core's data port.
// Word-aligned, byte-masked writes and word reads into a single-port word RAM
// with a registered read port. Out-of-window addresses answer SLVERR.

module axi_lite_data_ram #(
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready
);

   localparam int              IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] LIMIT  = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH_WORDS * 4);
   localparam logic [1:0]      OKAY   = 2'b00;
   localparam logic [1:0]      SLVERR = 2'b10;

   typedef enum logic [2:0] {
      W_IDLE,
      W_GOT_A,
      W_GOT_D,
      W_COMMIT,
      W_RESP
   } wrState_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rdState_t;

   // An address is served only if it falls inside the RAM's byte window.
   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
   endfunction

   // Word index relative to the window base; the two byte-offset bits drop out.
   function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   logic [31:0] ram [DEPTH_WORDS];

   wrState_t          wrState_q, wrState_d;
   rdState_t          rdState_q, rdState_d;
   logic [ADDR_W-1:0] awAddr_q, awAddr_d;
   logic [31:0]       wData_q, wData_d;
   logic [3:0]        wStrb_q, wStrb_d;
   logic [1:0]        bResp_q, bResp_d;
   logic [31:0]       rData_q, rData_d;
   logic [1:0]        rResp_q, rResp_d;

   logic awHs;
   logic wHs;
   logic arHs;
   logic ramWe;

   assign s_awready = (wrState_q == W_IDLE) || (wrState_q == W_GOT_D);
   assign s_wready  = (wrState_q == W_IDLE) || (wrState_q == W_GOT_A);
   assign s_arready = (rdState_q == R_IDLE) && (wrState_q != W_COMMIT);
   assign s_bvalid  = (wrState_q == W_RESP);
   assign s_bresp   = bResp_q;
   assign s_rvalid  = (rdState_q == R_DATA);
   assign s_rdata   = rData_q;
   assign s_rresp   = rResp_q;

   assign awHs  = s_awvalid && s_awready;
   assign wHs   = s_wvalid && s_wready;
   assign arHs  = s_arvalid && s_arready;
   assign ramWe = (wrState_q == W_COMMIT) && inRange(awAddr_q);

   // Write channel: collect address and data in either order, commit for one
   // cycle, then hold the response until the master takes it.
   always_comb begin
      wrState_d = wrState_q;
      awAddr_d  = awAddr_q;
      wData_d   = wData_q;
      wStrb_d   = wStrb_q;
      bResp_d   = bResp_q;
      if (awHs) begin
         awAddr_d = s_awaddr;
      end
      if (wHs) begin
         wData_d = s_wdata;
         wStrb_d = s_wstrb;
      end
      case (wrState_q)
         W_IDLE: begin
            if (awHs && wHs) begin
               wrState_d = W_COMMIT;
            end else if (awHs) begin
               wrState_d = W_GOT_A;
            end else if (wHs) begin
               wrState_d = W_GOT_D;
            end
         end
         W_GOT_A: begin
            if (wHs) begin
               wrState_d = W_COMMIT;
            end
         end
         W_GOT_D: begin
            if (awHs) begin
               wrState_d = W_COMMIT;
            end
         end
         W_COMMIT: begin
            bResp_d   = inRange(awAddr_q) ? OKAY : SLVERR;
            wrState_d = W_RESP;
         end
         W_RESP: begin
            if (s_bready) begin
               wrState_d = W_IDLE;
            end
         end
         default: begin
            wrState_d = W_IDLE;
         end
      endcase
   end

   // Read channel: a read is captured into the output register on the
   // address handshake and held until the master accepts it.
   always_comb begin
      rdState_d = rdState_q;
      rData_d   = rData_q;
      rResp_d   = rResp_q;
      case (rdState_q)
         R_IDLE: begin
            if (arHs) begin
               rdState_d = R_DATA;
               if (inRange(s_araddr)) begin
                  rData_d = ram[wordIdx(s_araddr)];
                  rResp_d = OKAY;
               end else begin
                  rData_d = '0;
                  rResp_d = SLVERR;
               end
            end
         end
         R_DATA: begin
            if (s_rready) begin
               rdState_d = R_IDLE;
            end
         end
         default: begin
            rdState_d = R_IDLE;
         end
      endcase
   end

   // Control and response registers; reset drops any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrState_q <= W_IDLE;
         rdState_q <= R_IDLE;
         awAddr_q  <= '0;
         wData_q   <= '0;
         wStrb_q   <= '0;
         bResp_q   <= OKAY;
         rData_q   <= '0;
         rResp_q   <= OKAY;
      end else begin
         wrState_q <= wrState_d;
         rdState_q <= rdState_d;
         awAddr_q  <= awAddr_d;
         wData_q   <= wData_d;
         wStrb_q   <= wStrb_d;
         bResp_q   <= bResp_d;
         rData_q   <= rData_d;
         rResp_q   <= rResp_d;
      end
   end

   // RAM write port: byte lanes enabled by the latched strobes, never reset.
   always_ff @(posedge clk) begin
      if (ramWe) begin
         for (int k = 0; k < 4; k++) begin
            if (wStrb_q[k]) begin
               ram[wordIdx(awAddr_q)][8*k +: 8] <= wData_q[8*k +: 8];
            end
         end
      end
   end

endmodule
